bank_port_sched: RTL and testbench
==================================

Name: bank_port_sched

Overview:
- Schedules the single read port and the write port of the register bank that holds cell colours.
- Two readers share the read port: the VGA renderer (high priority, bursty) and the 7-segment display scanner (low priority, with a starvation guard).
- Converts the keypad's level-held operation strobe into one write pulse per key press.
- Sits between Teclado/BancoRegistro/test_VGA/Display in the top level.

Parameters:
- AW, 4, bank address width (16 cells).
- DW, 3, bank data width (RGB colour code).
- MAX_WAIT, 8, max consecutive cycles a pending display request may be refused before it is forced to win (legal range 2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- vga_req  in  1  VGA read request, level.
- vga_addr  in  AW  VGA read address.
- vga_gnt  out  1  VGA owns the read port this cycle.
- vga_data  out  DW  registered read data for VGA.
- vga_valid  out  1  one-cycle pulse; vga_data is valid.
- disp_req  in  1  display read request, level.
- disp_addr  in  AW  display read address.
- disp_gnt  out  1  display owns the read port this cycle.
- disp_data  out  DW  registered read data for display.
- disp_valid  out  1  one-cycle pulse; disp_data is valid.
- key_opr  in  1  keypad operation strobe, level, may stay high many cycles.
- key_pos  in  AW  keypad cell position.
- key_data  in  DW  colour to write.
- bank_addr_r  out  AW  bank read address.
- bank_dat_r  in  DW  bank read data, combinational from bank_addr_r.
- bank_addr_w  out  AW  bank write address.
- bank_dat_w  out  DW  bank write data.
- bank_we  out  1  bank write enable, single-cycle pulse.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, all gnt/valid/bank_we=0, data outputs=0, bank_addr_r=0, wait_cnt=0, opr_q=0.
- A reset asserted mid-operation drops any in-flight read; no valid pulse follows.
- FSM state is registered: IDLE, RD_VGA, RD_DISP. vga_gnt=(state==RD_VGA), disp_gnt=(state==RD_DISP).
- Next-state decision at every edge:
  - force = disp_req && wait_cnt==MAX_WAIT-1.
  - force -> RD_DISP.
  - else vga_req -> RD_VGA.
  - else disp_req -> RD_DISP.
  - else IDLE.
- Back-to-back grants are allowed; there are no idle bubbles.
- On entering RD_x, bank_addr_r latches x_addr sampled at that edge. In IDLE, bank_addr_r holds its last value.
- At the edge ending RD_x: x_data <= bank_dat_r and x_valid=1 for exactly one cycle.
- Latency: request sampled at edge k, grant during cycle k..k+1, data/valid at edge k+1.
- wait_cnt:
  - Clears on any edge that enters RD_DISP or where disp_req=0.
  - Otherwise increments, saturating at MAX_WAIT-1.
- Write path:
  - opr_q <= key_opr.
  - Rising edge (key_opr && !opr_q) at edge k -> bank_we=1 during cycle k..k+1 with bank_addr_w/bank_dat_w = key_pos/key_data sampled at edge k.
  - Otherwise bank_we=0; bank_addr_w/bank_dat_w hold.
  - A held key_opr produces exactly one pulse.
  - key_opr must fall for at least 1 cycle before it can retrigger.
- The write port is independent of read arbitration; a write never stalls a read.
- Simultaneous write and read to the same address in the same cycle: see the optional feature.

Optional Feature:
- Macro: BANK_PORT_SCHED_WR_BYPASS_EN.
- Defined: if bank_we=1 and bank_addr_w==bank_addr_r during a grant cycle, the captured read data is bank_dat_w (new value).
- Undefined: the captured read data is bank_dat_r (old value); the new value is visible on the next read.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all requests high -> all gnt/valid/bank_we=0, bank_addr_r=0; first grant appears at the first edge after rst falls.
- VGA single read: bank cell 5=3'b110, vga_req=1 for one edge with vga_addr=5 -> vga_gnt 1 cycle, vga_valid pulse next edge, vga_data=3'b110.
- Starvation: vga_req and disp_req both held high, MAX_WAIT=8 -> display granted exactly once every 8 cycles; VGA gets the other 7; disp_valid period = 8 cycles.
- Key strobe: key_opr held high 50 cycles, key_pos=9, key_data=3'b011 -> exactly one bank_we pulse, addr 9, data 3'b011; a re-press after 2 low cycles gives a second pulse.
- Bypass: cell 2 = 3'b001, key write 3'b111 to 2 coinciding with a VGA grant on 2 -> vga_data=3'b111 with macro defined, 3'b001 without; the following read returns 3'b111 in both builds.
- Reset mid-read: rst=1 during an RD_DISP cycle -> no disp_valid pulse, state IDLE, wait_cnt=0.

Source files
------------

// File: rtl/bank_port_sched.sv
// bank_port_sched: arbitrates the single read port of the colour register bank
// between the VGA renderer (priority) and the display scanner (starvation guard),
// and turns the keypad's level-held strobe into one write pulse per press.
// Optional build macro: BANK_PORT_SCHED_WR_BYPASS_EN. When defined, a read that
// coincides with a write to the same cell returns the value being written.
module bank_port_sched #(
    parameter int AW       = 4,
    parameter int DW       = 3,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic [DW-1:0] vga_data,
    output logic          vga_valid,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          key_opr,
    input  logic [AW-1:0] key_pos,
    input  logic [DW-1:0] key_data,
    output logic [AW-1:0] bank_addr_r,
    input  logic [DW-1:0] bank_dat_r,
    output logic [AW-1:0] bank_addr_w,
    output logic [DW-1:0] bank_dat_w,
    output logic          bank_we
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_VGA  = 2'd1,
        RD_DISP = 2'd2
    } state_t;

    // MAX_WAIT is at most 255, so an 8-bit refusal counter always suffices.
    localparam logic [7:0] WAIT_TOP = 8'(MAX_WAIT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    wait_cnt;
    logic          force_disp;
    logic [DW-1:0] rd_cap;
    logic          opr_q;
    logic          wr_rise;

    assign vga_gnt  = (state == RD_VGA);
    assign disp_gnt = (state == RD_DISP);
    assign wr_rise  = key_opr && !opr_q;

    // Next owner of the read port: a starved display wins, then VGA, then display.
    always_comb begin
        state_nxt  = IDLE;
        force_disp = disp_req && (wait_cnt == WAIT_TOP);
        if (force_disp)
            state_nxt = RD_DISP;
        else if (vga_req)
            state_nxt = RD_VGA;
        else if (disp_req)
            state_nxt = RD_DISP;
    end

    // Read data captured at the end of a grant cycle.
`ifdef BANK_PORT_SCHED_WR_BYPASS_EN
    always_comb begin
        rd_cap = bank_dat_r;
        if (bank_we && (bank_addr_w == bank_addr_r))
            rd_cap = bank_dat_w;
    end
`else
    // Without bypass the bank's current (old) contents are returned.
    always_comb begin
        rd_cap = bank_dat_r;
    end
`endif

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latch the winner's address on grant; hold it while idle.
    always_ff @(posedge clk) begin
        if (rst)
            bank_addr_r <= '0;
        else if (state_nxt == RD_VGA)
            bank_addr_r <= vga_addr;
        else if (state_nxt == RD_DISP)
            bank_addr_r <= disp_addr;
    end

    // Return data to whichever reader owned the port in the cycle just ended.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_data   <= '0;
            vga_valid  <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            vga_valid  <= (state == RD_VGA);
            disp_valid <= (state == RD_DISP);
            if (state == RD_VGA)
                vga_data <= rd_cap;
            if (state == RD_DISP)
                disp_data <= rd_cap;
        end
    end

    // Count consecutive refused display requests, saturating at the force point.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (!disp_req || (state_nxt == RD_DISP))
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_TOP)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // One write pulse per keypad press; address/data hold between presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr_q       <= 1'b0;
            bank_we     <= 1'b0;
            bank_addr_w <= '0;
            bank_dat_w  <= '0;
        end else begin
            opr_q   <= key_opr;
            bank_we <= wr_rise;
            if (wr_rise) begin
                bank_addr_w <= key_pos;
                bank_dat_w  <= key_data;
            end
        end
    end

endmodule

// File: tb/tb_bank_port_sched.sv
// Directed bench for bank_port_sched: reset, single reads, starvation guard,
// key strobe edge detection, same-cell read/write, and reset during a read.
module tb_bank_port_sched;

    localparam int AW = 4;
    localparam int DW = 3;
    localparam int MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, disp_req, key_opr;
    logic [AW-1:0] vga_addr, disp_addr, key_pos;
    logic [DW-1:0] key_data;
    logic          vga_gnt, vga_valid, disp_gnt, disp_valid, bank_we;
    logic [DW-1:0] vga_data, disp_data, bank_dat_r, bank_dat_w;
    logic [AW-1:0] bank_addr_r, bank_addr_w;

    logic [DW-1:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;

    bank_port_sched #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_data(vga_data), .vga_valid(vga_valid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .key_opr(key_opr), .key_pos(key_pos), .key_data(key_data),
        .bank_addr_r(bank_addr_r), .bank_dat_r(bank_dat_r),
        .bank_addr_w(bank_addr_w), .bank_dat_w(bank_dat_w), .bank_we(bank_we)
    );

    always #5 clk = ~clk;

    // Register bank: preset contents while in reset, synchronous write.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[5] <= 3'b110;
            mem[2] <= 3'b001;
        end else if (bank_we) begin
            mem[bank_addr_w] <= bank_dat_w;
        end
    end
    assign bank_dat_r = mem[bank_addr_r];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ndg, nvg, last, nwe;

    initial begin
        rst = 1'b1; vga_req = 1'b1; disp_req = 1'b1; key_opr = 1'b1;
        vga_addr = '0; disp_addr = '0; key_pos = '0; key_data = '0;

        // Reset with all requests high.
        repeat (3) tick();
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_disp_gnt", disp_gnt, 0);
        chk("rst_vga_valid", vga_valid, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_we", bank_we, 0);
        chk("rst_addr_r", bank_addr_r, 0);
        rst = 1'b0; key_opr = 1'b0;
        tick();
        chk("first_gnt_vga", vga_gnt, 1);
        chk("first_gnt_disp", disp_gnt, 0);
        vga_req = 1'b0; disp_req = 1'b0;
        tick();
        chk("first_valid", vga_valid, 1);
        chk("first_idle", vga_gnt, 0);

        // Single VGA read of cell 5.
        vga_req = 1'b1; vga_addr = 4'd5;
        tick();
        chk("rd5_gnt", vga_gnt, 1);
        chk("rd5_addr", bank_addr_r, 5);
        chk("rd5_novalid", vga_valid, 0);
        vga_req = 1'b0;
        tick();
        chk("rd5_valid", vga_valid, 1);
        chk("rd5_data", vga_data, 3'b110);
        chk("rd5_gnt_off", vga_gnt, 0);
        tick();
        chk("rd5_pulse_end", vga_valid, 0);
        chk("rd5_addr_hold", bank_addr_r, 5);

        // Starvation guard: both readers continuously requesting.
        vga_req = 1'b1; disp_req = 1'b1; vga_addr = 4'd1; disp_addr = 4'd2;
        ndg = 0; nvg = 0; last = -1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (disp_gnt) ndg++;
            if (vga_gnt) nvg++;
            chk("starve_slot", disp_gnt, (i % 8 == 7) ? 1 : 0);
            if (disp_valid) begin
                if (last >= 0) chk("disp_period", i - last, 8);
                chk("disp_data", disp_data, 3'b001);
                last = i;
            end
        end
        chk("disp_grants", ndg, 4);
        chk("vga_grants", nvg, 28);
        vga_req = 1'b0; disp_req = 1'b0;
        tick();
        chk("starve_tail_valid", disp_valid, 1);
        tick();

        // Key held 50 cycles: one write pulse, then a re-press after 2 low cycles.
        key_opr = 1'b1; key_pos = 4'd9; key_data = 3'b011;
        nwe = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bank_we) begin
                nwe++;
                chk("key_addr", bank_addr_w, 9);
                chk("key_data", bank_dat_w, 3'b011);
            end
        end
        chk("key_pulses", nwe, 1);
        chk("key_mem", mem[9], 3'b011);
        key_opr = 1'b0;
        tick();
        tick();
        key_opr = 1'b1; key_data = 3'b101;
        tick();
        chk("repress_we", bank_we, 1);
        chk("repress_data", bank_dat_w, 3'b101);
        key_opr = 1'b0;
        tick();
        chk("repress_end", bank_we, 0);
        chk("repress_mem", mem[9], 3'b101);

        // Write to cell 2 in the same cycle VGA reads cell 2.
        vga_req = 1'b1; vga_addr = 4'd2;
        key_opr = 1'b1; key_pos = 4'd2; key_data = 3'b111;
        tick();
        chk("byp_gnt", vga_gnt, 1);
        chk("byp_we", bank_we, 1);
        vga_req = 1'b0; key_opr = 1'b0;
        tick();
        chk("byp_valid", vga_valid, 1);
`ifdef BANK_PORT_SCHED_WR_BYPASS_EN
        chk("byp_data", vga_data, 3'b111);
`else
        chk("byp_data", vga_data, 3'b001);
`endif
        vga_req = 1'b1;
        tick();
        vga_req = 1'b0;
        tick();
        chk("byp_reread", vga_data, 3'b111);

        // Reset during a display grant drops the read.
        disp_req = 1'b1; disp_addr = 4'd5;
        tick();
        chk("mid_gnt", disp_gnt, 1);
        rst = 1'b1;
        tick();
        chk("mid_no_valid", disp_valid, 0);
        chk("mid_disp_gnt", disp_gnt, 0);
        chk("mid_vga_gnt", vga_gnt, 0);
        chk("mid_wait_cnt", dut.wait_cnt, 0);
        chk("mid_addr_r", bank_addr_r, 0);
        rst = 1'b0; disp_req = 1'b0;
        tick();
        chk("mid_after_valid", disp_valid, 0);

        // Refusal count starts fresh after reset: display forced on the 8th edge.
        vga_req = 1'b1; disp_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_slot", disp_gnt, (i == 7) ? 1 : 0);
        end
        vga_req = 1'b0; disp_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
